// File: rtl/decode_control_unit.sv
// decode_control_unit: main control decoder plus ALU control decoder for the
// single-cycle RV32I-subset core. Decode is purely combinational; the only
// state is a sticky flag recording that an unsupported opcode was observed.
module decode_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       branch,
    output logic       alu_src,
    output logic [1:0] pc_src,
    output logic [2:0] imm_type,
    output logic [1:0] alu_op,
    output logic [3:0] alu_ctrl,
    output logic       illegal_op,
    output logic       illegal_seen
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [1:0] AOP_ADD  = 2'b00;
    localparam logic [1:0] AOP_SUB  = 2'b01;
    localparam logic [1:0] AOP_R    = 2'b10;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Main decoder: opcode to datapath controls; unknown opcodes decode to a safe no-op.
    always_comb begin
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        pc_src     = 2'b00;
        imm_type   = IMM_NONE;
        alu_op     = AOP_ADD;
        illegal_op = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_op    = AOP_R;
            end
            OP_IARITH: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_type  = IMM_I;
                alu_op    = 2'b11;
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
                imm_type   = IMM_I;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_type  = IMM_S;
            end
            OP_BRANCH: begin
                branch   = 1'b1;
                pc_src   = 2'b01;
                imm_type = IMM_B;
                alu_op   = AOP_SUB;
            end
            default: begin
                illegal_op = 1'b1;
            end
        endcase
    end

    // ALU decoder: class code plus funct fields to ALU operation; only funct7[5] matters.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            AOP_ADD: alu_ctrl = ALU_ADD;
            AOP_SUB: alu_ctrl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: begin
                        // ADDI has no subtract form, so funct7 is only honoured for R-type.
                        if ((alu_op == AOP_R) && funct7[5]) begin
                            alu_ctrl = ALU_SUB;
                        end else begin
                            alu_ctrl = ALU_ADD;
                        end
                    end
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: begin
                        if (funct7[5]) begin
                            alu_ctrl = ALU_SRA;
                        end else begin
                            alu_ctrl = ALU_SRL;
                        end
                    end
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

    // Sticky illegal-opcode flag: sets on any edge that sees an illegal opcode, clears only on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_seen <= 1'b0;
        end else begin
            illegal_seen <= illegal_seen | illegal_op;
        end
    end

endmodule

// File: tb/tb_decode_control_unit.sv
// Testbench for decode_control_unit: scoreboard of expected control vectors
// pushed as each instruction is driven and popped once outputs settle.
module tb_decode_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src;
    logic [1:0] pc_src;
    logic [2:0] imm_type;
    logic [1:0] alu_op;
    logic [3:0] alu_ctrl;
    logic       illegal_op;
    logic       illegal_seen;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [17:0] ctl;
        logic        seen;
        string       name;
    } exp_t;

    exp_t sb[$];

    // Packed control fields: {rw,mr,mw,m2r,br,asrc}, pc_src, imm_type, alu_op
    localparam logic [12:0] R_BASE  = {6'b100000, 2'b00, 3'b111, 2'b10};
    localparam logic [12:0] I_BASE  = {6'b100001, 2'b00, 3'b000, 2'b11};
    localparam logic [12:0] LD_BASE = {6'b110101, 2'b00, 3'b000, 2'b00};
    localparam logic [12:0] ST_BASE = {6'b001001, 2'b00, 3'b001, 2'b00};
    localparam logic [12:0] BR_BASE = {6'b000010, 2'b01, 3'b010, 2'b01};
    localparam logic [17:0] ILL_CTL = {6'b000000, 2'b00, 3'b111, 2'b00, 4'b0010, 1'b1};
    localparam logic [17:0] ADD_CTL = {R_BASE, 4'b0010, 1'b0};

    // ALU codes by funct3 for funct7[5]=0 and funct7[5]=1
    logic [3:0] r_alu0 [8] = '{4'b0010, 4'b0100, 4'b0111, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    logic [3:0] r_alu1 [8] = '{4'b0110, 4'b0100, 4'b0111, 4'b1001, 4'b0011, 4'b1000, 4'b0001, 4'b0000};
    logic [3:0] i_alu1 [8] = '{4'b0010, 4'b0100, 4'b0111, 4'b1001, 4'b0011, 4'b1000, 4'b0001, 4'b0000};

    logic [17:0] obs_ctl;
    assign obs_ctl = {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src,
                      pc_src, imm_type, alu_op, alu_ctrl, illegal_op};

    decode_control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .branch       (branch),
        .alu_src      (alu_src),
        .pc_src       (pc_src),
        .imm_type     (imm_type),
        .alu_op       (alu_op),
        .alu_ctrl     (alu_ctrl),
        .illegal_op   (illegal_op),
        .illegal_seen (illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_vec(input logic [31:0] instr, input logic [17:0] ctl,
                            input logic seen, input string nm);
        exp_t e;
        opcode = instr[6:0];
        funct3 = instr[14:12];
        funct7 = instr[31:25];
        e.ctl  = ctl;
        e.seen = seen;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        push_vec(32'h00000033, ADD_CTL, 1'b0, "reset_decode");
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front();
        vectors += 2;
        if (obs_ctl !== e.ctl) begin
            miscompares++;
            $display("FAIL %s ctl: got %b expected %b", e.name, obs_ctl, e.ctl);
        end
        if (illegal_seen !== e.seen) begin
            miscompares++;
            $display("FAIL %s seen: got %b expected %b", e.name, illegal_seen, e.seen);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_vec(32'h00000033, ADD_CTL, 1'b0, "post_reset");
        #1;
        e = sb.pop_front();
        vectors += 2;
        if (obs_ctl !== e.ctl) begin
            miscompares++;
            $display("FAIL %s ctl: got %b expected %b", e.name, obs_ctl, e.ctl);
        end
        if (illegal_seen !== e.seen) begin
            miscompares++;
            $display("FAIL %s seen: got %b expected %b", e.name, illegal_seen, e.seen);
        end
    endtask

    task automatic test_rtype();
        exp_t e;
        logic [2:0] f3;
        // funct7 values: 0x00, 0x20, plus 0x1F / 0x5F to show only bit 5 is inspected
        logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h1F, 7'h5F};
        for (int f = 0; f < 8; f++) begin
            for (int h = 0; h < 4; h++) begin
                f3 = f[2:0];
                push_vec({f7s[h], 10'd0, f3, 5'd0, 7'b0110011},
                         {R_BASE, (f7s[h][5] ? r_alu1[f] : r_alu0[f]), 1'b0}, 1'b0, "rtype");
                #1;
                e = sb.pop_front();
                vectors++;
                if (obs_ctl !== e.ctl) begin
                    miscompares++;
                    $display("FAIL %s f3=%0d f7=%h ctl: got %b expected %b",
                             e.name, f, f7s[h], obs_ctl, e.ctl);
                end
            end
        end
    endtask

    task automatic test_iarith();
        exp_t e;
        logic [2:0] f3;
        for (int f = 0; f < 8; f++) begin
            for (int h = 0; h < 2; h++) begin
                f3 = f[2:0];
                push_vec({(h == 1) ? 7'h20 : 7'h00, 10'd0, f3, 5'd0, 7'b0010011},
                         {I_BASE, ((h == 1) ? i_alu1[f] : r_alu0[f]), 1'b0}, 1'b0, "iarith");
                #1;
                e = sb.pop_front();
                vectors++;
                if (obs_ctl !== e.ctl) begin
                    miscompares++;
                    $display("FAIL %s f3=%0d h=%0d ctl: got %b expected %b",
                             e.name, f, h, obs_ctl, e.ctl);
                end
            end
        end
    endtask

    task automatic test_mem_branch();
        exp_t e;
        logic [31:0] instrs [6] = '{32'h00002003, 32'h00002023, 32'h00000063,
                                     32'hFE007063, 32'h40005003, 32'h40000023};
        logic [17:0] ctls [6];
        string       names [6] = '{"lw", "sw", "beq", "bgeu_f7", "load_f7", "store_f7"};
        ctls[0] = {LD_BASE, 4'b0010, 1'b0};
        ctls[1] = {ST_BASE, 4'b0010, 1'b0};
        ctls[2] = {BR_BASE, 4'b0110, 1'b0};
        ctls[3] = {BR_BASE, 4'b0110, 1'b0};
        ctls[4] = {LD_BASE, 4'b0010, 1'b0};
        ctls[5] = {ST_BASE, 4'b0010, 1'b0};
        for (int i = 0; i < 6; i++) begin
            push_vec(instrs[i], ctls[i], 1'b0, names[i]);
            #1;
            e = sb.pop_front();
            vectors++;
            if (obs_ctl !== e.ctl) begin
                miscompares++;
                $display("FAIL %s ctl: got %b expected %b", e.name, obs_ctl, e.ctl);
            end
        end
        // Flag must still be clear after a run of legal instructions across clock edges
        @(posedge clk);
        #1;
        vectors++;
        if (illegal_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL legal_run seen: got %b expected 0", illegal_seen);
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        // Step list: drive, then optional clock edge, then compare both ctl and sticky flag
        logic [31:0] instrs [9] = '{32'h7F, 32'h7F, 32'h7F, 32'h7F, 32'h33, 32'h33,
                                     32'h33, 32'h37, 32'h37};
        logic        rsts   [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        edges  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        seens  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        string       names  [9] = '{"ill_in_rst", "ill_rst_edge", "ill_pre_edge", "ill_post_edge",
                                    "add_after_ill", "add_sticky", "mid_cycle_rst",
                                    "lui_in_rst", "lui_first_edge"};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 6) begin
                // Assert reset away from both edges to show the clear is asynchronous
                #2;
            end
            rst = rsts[i];
            push_vec(instrs[i], (instrs[i] == 32'h33) ? ADD_CTL : ILL_CTL, seens[i], names[i]);
            if (edges[i]) begin
                @(posedge clk);
            end
            #1;
            e = sb.pop_front();
            vectors += 2;
            if (obs_ctl !== e.ctl) begin
                miscompares++;
                $display("FAIL %s ctl: got %b expected %b", e.name, obs_ctl, e.ctl);
            end
            if (illegal_seen !== e.seen) begin
                miscompares++;
                $display("FAIL %s seen: got %b expected %b", e.name, illegal_seen, e.seen);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 7'd0;
        funct3 = 3'd0;
        funct7 = 7'd0;
        test_reset();
        test_rtype();
        test_iarith();
        test_mem_branch();
        test_illegal();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_control_unit.md
# decode_control_unit

Instruction-decode control block for the single-cycle RV32I-subset processor. It combines the main control decoder (`control_unit`) and the ALU control decoder (`alu_control`). It maps an instruction's opcode/funct3/funct7 fields to datapath control signals and a 4-bit ALU operation code. Decode is purely combinational. The only clocked element is a sticky illegal-opcode flag for debug/trap use.

## Interface
Parameters: none.

Ports:
- `clk` input 1: system clock. Only the sticky flag uses it.
- `rst` input 1: reset, asynchronous, active-high. Clears the sticky flag.
- `opcode` input 7: instr[6:0].
- `funct3` input 3: instr[14:12].
- `funct7` input 7: instr[31:25].
- `reg_write` output 1: write the register file.
- `mem_read` output 1: data-memory read enable.
- `mem_write` output 1: data-memory write enable.
- `mem_to_reg` output 1: write-back source. 1 = memory data, 0 = ALU result.
- `branch` output 1: conditional branch instruction. The datapath ANDs it with the ALU zero/compare result.
- `alu_src` output 1: ALU operand B select. 1 = immediate, 0 = rs2.
- `pc_src` output 2: next-PC select. 00 = PC+4, 01 = PC+imm (branch target), 10/11 never driven.
- `imm_type` output 3: immediate format. 000 = I, 001 = S, 010 = B, 111 = none.
- `alu_op` output 2: class code from main decoder to ALU decoder. 00 = add, 01 = subtract, 10 = R-type, 11 = I-arith.
- `alu_ctrl` output 4: ALU operation.
- `illegal_op` output 1: combinational; current opcode is unsupported.
- `illegal_seen` output 1: registered sticky flag.

## Operation
Main decoder, by opcode. Fields are listed as reg_write/mem_read/mem_write/mem_to_reg/branch/alu_src, then pc_src, imm_type, alu_op:
- `0110011` R-type: 1/0/0/0/0/0, 00, 111, 10.
- `0010011` I-arith: 1/0/0/0/0/1, 00, 000, 11.
- `0000011` LOAD: 1/1/0/1/0/1, 00, 000, 00.
- `0100011` STORE: 0/0/1/0/0/1, 00, 001, 00.
- `1100011` BRANCH: 0/0/0/0/1/0, 01, 010, 01.
- Any other opcode: all 1-bit outputs 0, pc_src 00, imm_type 111, alu_op 00, illegal_op 1.
- illegal_op is 0 for the five supported opcodes.

ALU decoder, alu_ctrl encoding:
- ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLL 0100, SRL 0101, SRA 1000, SLT 0111, SLTU 1001.

ALU decoder, mapping:
- alu_op 00 → ADD, regardless of funct fields.
- alu_op 01 → SUB, regardless of funct fields.
- alu_op 10 (R-type), by funct3:
  - 000: SUB if funct7[5]=1, else ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRA if funct7[5]=1, else SRL.
  - 110 OR, 111 AND.
- alu_op 11 (I-arith): same as alu_op 10 except funct3 000 is always ADD (ADDI never subtracts). funct3 101 still uses funct7[5] (SRAI/SRLI).
- Only funct7[5] is inspected. Other funct7 bits are ignored, and no illegal-funct detection is done.

Sticky flag:
- On each rising `clk`, `illegal_seen` becomes `illegal_seen | illegal_op`.
- Once set, it stays set until `rst`.

## Timing
- All decode outputs are combinational from `opcode`/`funct3`/`funct7`: zero-cycle latency, no clock dependence. They settle within the same delta cycle as their inputs and are valid during reset.
- `illegal_seen` resets to 0 asynchronously while `rst`=1.
- If `illegal_op`=1 at a rising edge while `rst`=0, `illegal_seen`=1 from that edge onward.
- If `rst` is asserted while `illegal_op`=1, `illegal_seen` stays 0 for the whole reset assertion.
- The first rising edge after reset deassertion with `illegal_op`=1 sets `illegal_seen`.
- Outputs never go X/Z for any 2-state input combination. Every case statement has a default.

## Test plan
- R ADD (instr 0x00000033) → reg_write 1, mem_read 0, mem_write 0, mem_to_reg 0, branch 0, alu_src 0, alu_ctrl 0010, pc_src 00, imm_type 111.
- R SUB (instr 0x40000033) → same as ADD except alu_ctrl 0110. Then sweep funct3 001–111 with funct7 0x00/0x20 → SLL 0100, SLT 0111, SLTU 1001, XOR 0011, SRL 0101 / SRA 1000, OR 0001, AND 0000.
- LOAD lw (instr 0x00002003) → 1/1/0/1/0/1, alu_ctrl 0010, pc_src 00, imm_type 000.
- STORE sw (instr 0x00002023) → 0/0/1/0/0/1, alu_ctrl 0010, pc_src 00, imm_type 001.
- BEQ (instr 0x00000063) → 0/0/0/0/1/0, alu_ctrl 0110, pc_src 01, imm_type 010.
- ADDI (instr 0x00000013), then instr 0x40000013 → both give alu_ctrl 0010 with reg_write 1, alu_src 1, imm_type 000. SRAI (0x40005013) → 1000.
- Illegal opcode 0x7F sequence:
  - assert rst → illegal_seen 0.
  - release rst, apply opcode 0x7F → illegal_op 1 and all controls 0 immediately; illegal_seen 1 after the next rising clk.
  - return to an ADD → illegal_seen stays 1.
  - assert rst mid-cycle → illegal_seen 0 asynchronously.
